// File: rtl/bus_master_pkg.sv
// Shared types and constants for the DMA-style bus master and its timeout counter.
package bus_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_ADDR = 3'd2,
        ST_STB  = 3'd3,
        ST_REL  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    localparam int TIMEOUT_DEFAULT = 64;
    localparam int ADDR_W          = 16;
    localparam int DATA_W          = 16;
    localparam int CNT_W           = 8;

    // An all-zero byte-enable request means "whole word".
    function automatic logic [1:0] norm_wtbt(input logic [1:0] wtbt);
        return (wtbt == 2'b00) ? 2'b11 : wtbt;
    endfunction

endpackage

// File: rtl/bus_master_timeout.sv
// Saturating 8-bit STB-phase counter; expired flags the last permitted wait cycle.
module bus_timeout
    import bus_master_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEFAULT
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LIMIT_M1);

endmodule

// File: rtl/bus_master.sv
// Single-transfer bus master: arbitrates for the bus, runs one ADDR/STB/REL cycle, reports done/err.
module bus_master
    import bus_master_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              cmd_req,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_we,
    input  logic [1:0]        cmd_wtbt,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              cmd_busy,
    output logic              cmd_done,
    output logic              cmd_err,
    output logic [DATA_W-1:0] cmd_rdata,
    output logic              dma_req,
    input  logic              dma_grant,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_sync,
    output logic              bus_stb,
    output logic              bus_we,
    output logic [1:0]        bus_wtbt,
    output logic [DATA_W-1:0] bus_din,
    input  logic [DATA_W-1:0] bus_dout,
    input  logic              bus_ack
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [1:0]          wtbt_q, wtbt_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cmd_err_q, cmd_err_d;
    logic                dma_req_q, dma_req_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic                bus_sync_q, bus_sync_d;
    logic                bus_stb_q, bus_stb_d;
    logic                bus_we_q, bus_we_d;
    logic [1:0]          bus_wtbt_q, bus_wtbt_d;
    logic [DATA_W-1:0]   bus_din_q, bus_din_d;

    logic                tmo_clear;
    logic                tmo_enable;
    logic                tmo_expired;

    // Counter is held at zero everywhere except STB, so it starts fresh on every STB entry.
    assign tmo_clear  = (state_q != ST_STB);
    assign tmo_enable = (state_q == ST_STB) && !bus_ack;

    bus_timeout #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wtbt_d  = wtbt_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_req) begin
                    addr_d  = cmd_addr;
                    we_d    = cmd_we;
                    wtbt_d  = norm_wtbt(cmd_wtbt);
                    wdata_d = cmd_wdata;
                    err_d   = 1'b0;
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (dma_grant) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                state_d = ST_STB;
            end
            ST_STB: begin
                if (bus_ack) begin
                    if (!we_q) begin
                        rdata_d = bus_dout;
                    end
                    state_d = ST_REL;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_REL;
                end
            end
            ST_REL: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with the state.
    always_comb begin
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        cmd_err_d  = (state_d == ST_DONE) && err_d;
        dma_req_d  = (state_d == ST_ARB) || (state_d == ST_ADDR) ||
                     (state_d == ST_STB) || (state_d == ST_REL);
        bus_sync_d = (state_d == ST_ADDR) || (state_d == ST_STB) || (state_d == ST_REL);
        bus_stb_d  = (state_d == ST_STB);
        bus_addr_d = bus_sync_d ? addr_d : '0;
        bus_we_d   = bus_sync_d && we_d;
        bus_wtbt_d = bus_sync_d ? wtbt_d : 2'b00;
        bus_din_d  = (bus_sync_d && we_d) ? wdata_d : '0;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wtbt_q     <= 2'b00;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cmd_err_q  <= 1'b0;
            dma_req_q  <= 1'b0;
            bus_addr_q <= '0;
            bus_sync_q <= 1'b0;
            bus_stb_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_wtbt_q <= 2'b00;
            bus_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wtbt_q     <= wtbt_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cmd_err_q  <= cmd_err_d;
            dma_req_q  <= dma_req_d;
            bus_addr_q <= bus_addr_d;
            bus_sync_q <= bus_sync_d;
            bus_stb_q  <= bus_stb_d;
            bus_we_q   <= bus_we_d;
            bus_wtbt_q <= bus_wtbt_d;
            bus_din_q  <= bus_din_d;
        end
    end

    assign cmd_busy  = busy_q;
    assign cmd_done  = done_q;
    assign cmd_err   = cmd_err_q;
    assign cmd_rdata = rdata_q;
    assign dma_req   = dma_req_q;
    assign bus_addr  = bus_addr_q;
    assign bus_sync  = bus_sync_q;
    assign bus_stb   = bus_stb_q;
    assign bus_we    = bus_we_q;
    assign bus_wtbt  = bus_wtbt_q;
    assign bus_din   = bus_din_q;

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master: a one-register responder plus a scoreboard of expected completions.
module tb_bus_master;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        cmd_req;
    logic [15:0] cmd_addr;
    logic        cmd_we;
    logic [1:0]  cmd_wtbt;
    logic [15:0] cmd_wdata;
    logic        cmd_busy, cmd_done, cmd_err;
    logic [15:0] cmd_rdata;
    logic        dma_req, dma_grant;
    logic [15:0] bus_addr;
    logic        bus_sync, bus_stb, bus_we;
    logic [1:0]  bus_wtbt;
    logic [15:0] bus_din, bus_dout;
    logic        bus_ack;

    logic        ack_en;
    logic [1:0]  exp_wtbt;
    logic [15:0] resp_q;
    logic [15:0] resp_addr_q;
    int          stb_cycles, stb_rises, wtbt_bad, read_bad;
    logic        stb_prev;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic        err;
        logic        chk_rd;
        logic [15:0] rdata;
        string       tag;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk_sys = ~clk_sys;

    bus_master #(.TIMEOUT(64)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .cmd_req   (cmd_req),
        .cmd_addr  (cmd_addr),
        .cmd_we    (cmd_we),
        .cmd_wtbt  (cmd_wtbt),
        .cmd_wdata (cmd_wdata),
        .cmd_busy  (cmd_busy),
        .cmd_done  (cmd_done),
        .cmd_err   (cmd_err),
        .cmd_rdata (cmd_rdata),
        .dma_req   (dma_req),
        .dma_grant (dma_grant),
        .bus_addr  (bus_addr),
        .bus_sync  (bus_sync),
        .bus_stb   (bus_stb),
        .bus_we    (bus_we),
        .bus_wtbt  (bus_wtbt),
        .bus_din   (bus_din),
        .bus_dout  (bus_dout),
        .bus_ack   (bus_ack)
    );

    // Responder: acknowledges combinationally from the strobe, one byte-laned register.
    assign bus_ack  = bus_stb && ack_en;
    assign bus_dout = resp_q;

    always @(posedge clk_sys) begin
        stb_prev <= bus_stb;
        if (bus_stb) begin
            stb_cycles <= stb_cycles + 1;
            if (bus_wtbt !== exp_wtbt) wtbt_bad <= wtbt_bad + 1;
            if (!bus_we && bus_din !== 16'h0) read_bad <= read_bad + 1;
        end
        if (bus_stb && !stb_prev) stb_rises <= stb_rises + 1;
        if (bus_stb && bus_ack && bus_we) begin
            resp_addr_q <= bus_addr;
            if (bus_wtbt[1]) resp_q[15:8] <= bus_din[15:8];
            if (bus_wtbt[0]) resp_q[7:0]  <= bus_din[7:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the first negedge after the request edge.
    task automatic issue(input logic [15:0] a, input logic we, input logic [1:0] wt,
                         input logic [15:0] d, input logic push, input exp_t e);
        cmd_addr  = a;
        cmd_we    = we;
        cmd_wtbt  = wt;
        cmd_wdata = d;
        cmd_req   = 1'b1;
        if (push) exp_q.push_back(e);
        @(negedge clk_sys);
        cmd_req   = 1'b0;
        cmd_addr  = 16'h0;
        cmd_wdata = 16'h0;
    endtask

    task automatic wait_done(input int start, output int lat);
        exp_t e;
        lat = start;
        while (!cmd_done && lat < 300) begin
            @(negedge clk_sys);
            lat++;
        end
        check("done_seen", {31'b0, cmd_done}, 32'd1);
        if (cmd_done) begin
            check("busy_at_done", {31'b0, cmd_busy}, 32'd1);
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check({e.tag, "_err"}, {31'b0, cmd_err}, {31'b0, e.err});
                if (e.chk_rd) check({e.tag, "_rdata"}, {16'b0, cmd_rdata}, {16'b0, e.rdata});
            end
        end
        $display("done %s lat=%0d err=%0b rdata=%o", cmd_done ? "seen" : "missing",
                 lat, cmd_err, cmd_rdata);
    endtask

    initial begin
        int   lat, bad, done_cnt, base_cyc, base_rise, base_wbad, base_rbad;
        exp_t e;

        reset_n = 1'b0; cmd_req = 1'b0; cmd_addr = 16'h0; cmd_we = 1'b0;
        cmd_wtbt = 2'b00; cmd_wdata = 16'h0; dma_grant = 1'b1; ack_en = 1'b1;
        exp_wtbt = 2'b11;
        resp_q = 16'h0; resp_addr_q = 16'h0; stb_prev = 1'b0;
        stb_cycles = 0; stb_rises = 0; wtbt_bad = 0; read_bad = 0;
        repeat (2) @(negedge clk_sys);
        check("reset_outputs",
              {1'b0, cmd_busy, cmd_done, cmd_err, dma_req, bus_sync, bus_stb, bus_we,
               bus_wtbt, 22'b0}, 32'd0);
        check("reset_buses", {cmd_rdata, bus_addr | bus_din}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk_sys);

        // Full-word write, grant already high, immediate ack.
        base_rise = stb_rises;
        e = '{err: 1'b0, chk_rd: 1'b0, rdata: 16'h0, tag: "write"};
        issue(16'o177664, 1'b1, 2'b11, 16'o001330, 1'b1, e);
        check("busy_after_accept", {31'b0, cmd_busy}, 32'd1);
        wait_done(1, lat);
        check("write_latency", lat, 32'd5);
        check("write_stb_pulses", stb_rises - base_rise, 32'd1);
        check("write_resp_value", {16'b0, resp_q}, {16'b0, 16'o001330});
        check("write_resp_addr", {16'b0, resp_addr_q}, {16'b0, 16'o177664});
        @(negedge clk_sys);
        check("idle_after_write", {29'b0, cmd_busy, cmd_done, bus_sync}, 32'd0);

        // Read back the same register.
        base_rbad = read_bad;
        e = '{err: 1'b0, chk_rd: 1'b1, rdata: 16'o001330, tag: "read"};
        issue(16'o177664, 1'b0, 2'b11, 16'hFFFF, 1'b1, e);
        wait_done(1, lat);
        check("read_latency", lat, 32'd5);
        check("read_we_din_zero", read_bad - base_rbad, 32'd0);
        @(negedge clk_sys);

        // Grant withheld: the bus must stay untouched while dma_req is held; a stray request is ignored.
        dma_grant = 1'b0;
        resp_q    = 16'h5A3C;
        e = '{err: 1'b0, chk_rd: 1'b1, rdata: 16'h5A3C, tag: "grant_wait"};
        issue(16'o177664, 1'b0, 2'b11, 16'h0, 1'b1, e);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_sync !== 1'b0 || dma_req !== 1'b1 || cmd_done !== 1'b0) bad++;
            cmd_req = (i == 5);
            @(negedge clk_sys);
        end
        cmd_req = 1'b0;
        check("grant_low_hold", bad, 32'd0);
        dma_grant = 1'b1;
        wait_done(0, lat);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_sys);
            if (cmd_busy !== 1'b0 || dma_req !== 1'b0) bad++;
        end
        check("stray_req_ignored", bad, 32'd0);

        // No responder: 64 strobe cycles then a timeout error; read data is left alone.
        ack_en    = 1'b0;
        base_cyc  = stb_cycles;
        base_rise = stb_rises;
        e = '{err: 1'b1, chk_rd: 1'b1, rdata: 16'h5A3C, tag: "timeout"};
        issue(16'o177700, 1'b0, 2'b11, 16'h0, 1'b1, e);
        wait_done(1, lat);
        check("timeout_stb_cycles", stb_cycles - base_cyc, 32'd64);
        check("timeout_stb_pulses", stb_rises - base_rise, 32'd1);
        @(negedge clk_sys);
        check("bus_idle_after_timeout",
              {bus_addr, 9'b0, bus_sync, bus_stb, bus_we, dma_req, cmd_err, bus_wtbt},
              32'd0);
        ack_en = 1'b1;

        // High-byte-only write.
        resp_q    = 16'o001330;
        exp_wtbt  = 2'b10;
        base_wbad = wtbt_bad;
        e = '{err: 1'b0, chk_rd: 1'b0, rdata: 16'h0, tag: "byte_write"};
        issue(16'o177663, 1'b1, 2'b10, 16'h4F00, 1'b1, e);
        wait_done(1, lat);
        check("byte_wtbt_in_stb", wtbt_bad - base_wbad, 32'd0);
        check("byte_resp_value", {16'b0, resp_q}, {16'b0, 16'h4FD8});
        check("rdata_held_over_write", {16'b0, cmd_rdata}, {16'b0, 16'h5A3C});
        exp_wtbt = 2'b11;
        @(negedge clk_sys);

        // Reset in the middle of a strobe.
        ack_en = 1'b0;
        e = '{err: 1'b0, chk_rd: 1'b0, rdata: 16'h0, tag: "aborted"};
        issue(16'o177664, 1'b1, 2'b11, 16'h1111, 1'b0, e);
        bad = 0;
        while (!bus_stb && bad < 20) begin
            @(negedge clk_sys);
            bad++;
        end
        check("stb_reached_before_reset", {31'b0, bus_stb}, 32'd1);
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b0;
        @(negedge clk_sys);
        check("reset_drops_bus", {28'b0, bus_stb, bus_sync, cmd_busy, dma_req}, 32'd0);
        reset_n = 1'b1;
        ack_en  = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys);
            if (cmd_done) done_cnt++;
        end
        check("no_done_after_reset", done_cnt, 32'd0);

        // Request after reset completes; zero byte enables write the whole word.
        e = '{err: 1'b0, chk_rd: 1'b0, rdata: 16'h0, tag: "post_reset"};
        issue(16'o177664, 1'b1, 2'b00, 16'hA5C3, 1'b1, e);
        wait_done(1, lat);
        check("post_reset_latency", lat, 32'd5);
        check("wtbt00_full_word", {16'b0, resp_q}, {16'b0, 16'hA5C3});
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
